axi4_lite_master: RTL and testbench

AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

---
 rtl/axi4_lite_pkg.sv | 22 ++
 rtl/axi4_lite_master.sv | 142 ++++++++++++++
 tb/tb_axi4_lite_master.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared response codes, FSM states and bus defaults for the AXI4-Lite master
package axi4_lite_pkg;

    localparam int AXI_ADDR_W = 4;
    localparam int AXI_DATA_W = 32;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_DATA
    } master_state_e;

endpackage

// File: rtl/axi4_lite_master.sv
// rtl/axi4_lite_master.sv - single-outstanding AXI4-Lite master driven by a simple command port
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = AXI_DATA_W
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              done,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_resp,
    output logic [ADDR_W-1:0] AWADDR,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [DATA_W-1:0] WDATA,
    output logic [3:0]        WSTRB,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY,
    output logic [ADDR_W-1:0] ARADDR,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RVALID,
    output logic              RREADY
);

    master_state_e     state_q;
    logic [ADDR_W-1:0] awaddr_q, araddr_q;
    logic [DATA_W-1:0] wdata_q, rsp_data_q;
    logic [1:0]        rsp_resp_q;
    logic              awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, done_q;
    logic              aw_done_q, w_done_q;
    logic              aw_hs, w_hs;

    assign aw_hs = awvalid_q & AWREADY;
    assign w_hs  = wvalid_q & WREADY;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= ST_IDLE;
            awaddr_q   <= '0;
            araddr_q   <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            rsp_resp_q <= RESP_OKAY;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            done_q     <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_write) begin
                            awaddr_q  <= cmd_addr;
                            wdata_q   <= cmd_wdata;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            state_q   <= ST_WR_REQ;
                        end else begin
                            araddr_q  <= cmd_addr;
                            arvalid_q <= 1'b1;
                            state_q   <= ST_RD_REQ;
                        end
                    end
                end
                ST_WR_REQ: begin
                    // AW and W retire independently; leave once both have been seen
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (BVALID) begin
                        bready_q   <= 1'b0;
                        rsp_resp_q <= BRESP;
                        done_q     <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_RD_REQ: begin
                    if (ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (RVALID) begin
                        rready_q   <= 1'b0;
                        rsp_data_q <= RDATA;
                        rsp_resp_q <= RRESP;
                        done_q     <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign done      = done_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_resp  = rsp_resp_q;
    assign AWADDR    = awaddr_q;
    assign AWVALID   = awvalid_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = 4'hF;
    assign WVALID    = wvalid_q;
    assign BREADY    = bready_q;
    assign ARADDR    = araddr_q;
    assign ARVALID   = arvalid_q;
    assign RREADY    = rready_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// tb/tb_axi4_lite_master.sv - randomized scoreboard bench for axi4_lite_master with a delay-programmable slave
module tb_axi4_lite_master;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        done;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic [3:0]  AWADDR, ARADDR;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;

    always #5 ACLK = ~ACLK;

    axi4_lite_master dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .done(done), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave: each channel waits a programmable number of cycles before responding
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    logic [1:0]  cur_resp = 2'b00;
    logic        stray_b = 1'b0, stray_r = 1'b0;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic        aw_got, w_got, b_pend, r_pend;
    logic [3:0]  s_awaddr;
    logic [31:0] s_wdata, s_rdata;
    logic [31:0] mem_s [4];

    assign AWREADY = AWVALID && (aw_cnt >= aw_dly);
    assign WREADY  = WVALID && (w_cnt >= w_dly);
    assign ARREADY = ARVALID && (ar_cnt >= ar_dly);
    assign BVALID  = (b_pend && (b_cnt >= b_dly)) || stray_b;
    assign RVALID  = (r_pend && (r_cnt >= r_dly)) || stray_r;
    assign BRESP   = cur_resp;
    assign RRESP   = cur_resp;
    assign RDATA   = s_rdata;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            s_awaddr <= '0; s_wdata <= '0; s_rdata <= '0;
        end else begin
            aw_cnt <= (AWVALID && !AWREADY) ? aw_cnt + 1 : 0;
            w_cnt  <= (WVALID && !WREADY) ? w_cnt + 1 : 0;
            ar_cnt <= (ARVALID && !ARREADY) ? ar_cnt + 1 : 0;
            if (AWVALID && AWREADY) begin aw_got <= 1'b1; s_awaddr <= AWADDR; end
            if (WVALID && WREADY) begin w_got <= 1'b1; s_wdata <= WDATA; end
            if ((aw_got || (AWVALID && AWREADY)) && (w_got || (WVALID && WREADY)) && !b_pend) begin
                mem_s[(AWVALID && AWREADY) ? AWADDR[3:2] : s_awaddr[3:2]] <=
                    (WVALID && WREADY) ? WDATA : s_wdata;
                aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1; b_cnt <= 0;
            end else if (b_pend) begin
                if (BVALID && BREADY) b_pend <= 1'b0;
                else b_cnt <= b_cnt + 1;
            end
            if (ARVALID && ARREADY) begin
                r_pend <= 1'b1; r_cnt <= 0; s_rdata <= mem_s[ARADDR[3:2]];
            end else if (r_pend) begin
                if (RVALID && RREADY) r_pend <= 1'b0;
                else r_cnt <= r_cnt + 1;
            end
        end
    end

    // Reference model and expectation ring, filled on each accept edge
    logic [31:0] model_mem [4];
    logic [31:0] model_rd = '0;
    bit          exp_wr   [256];
    logic [31:0] exp_data [256];
    logic [1:0]  exp_resp [256];
    int          exp_acc  [256];
    bit          exp_lat  [256];
    int          wr_ptr = 0, rd_ptr = 0;
    int          cyc = 0, accepts = 0, last_acc = 0, hold_accs = 0;
    int          aw_hi = 0, w_hi = 0, early = 0, dones = 0;
    bit          hold_mode = 1'b0;
    bit          aw_pend, w_pend, ar_pend;
    logic [3:0]  aw_prev, ar_prev;
    logic [31:0] w_prev;

    always @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            model_rd = '0;
            aw_pend = 1'b0; w_pend = 1'b0; ar_pend = 1'b0;
        end else begin
            cyc++;
            if (AWVALID) aw_hi++;
            if (WVALID) w_hi++;
            if (BREADY && (AWVALID || WVALID)) early++;
            aw_pend = AWVALID && !AWREADY; aw_prev = AWADDR;
            w_pend  = WVALID && !WREADY;   w_prev  = WDATA;
            ar_pend = ARVALID && !ARREADY; ar_prev = ARADDR;
            if (!hold_mode) hold_accs = 0;
            if (cmd_valid && cmd_ready) begin
                int idx;
                idx = wr_ptr % 256;
                if (hold_mode && hold_accs > 0) check("hold_spacing", cyc - last_acc, 3);
                if (hold_mode) hold_accs++;
                accepts++;
                last_acc = cyc;
                aw_hi = 0; w_hi = 0; early = 0;
                exp_wr[idx]   = cmd_write;
                exp_resp[idx] = cur_resp;
                exp_acc[idx]  = cyc;
                exp_lat[idx]  = (aw_dly == 0 && w_dly == 0 && ar_dly == 0 && b_dly == 0 && r_dly == 0);
                if (cmd_write) model_mem[cmd_addr[3:2]] = cmd_wdata;
                else model_rd = model_mem[cmd_addr[3:2]];
                exp_data[idx] = model_rd;
                wr_ptr++;
            end
        end
    end

    always @(negedge ACLK) begin
        if (ARESET) begin
            rd_ptr = wr_ptr;
        end else begin
            if (done) begin
                if (rd_ptr == wr_ptr) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done=1 expected no outstanding command at %0t", $time);
                end else begin
                    int idx;
                    idx = rd_ptr % 256;
                    check(exp_wr[idx] ? "wr_rsp_data" : "rd_rsp_data", rsp_data, exp_data[idx]);
                    check("rsp_resp", {30'd0, rsp_resp}, {30'd0, exp_resp[idx]});
                    // done is sampled at the third rising edge after the accept edge
                    if (exp_lat[idx]) check("latency", cyc + 1 - exp_acc[idx], 3);
                    rd_ptr++;
                    dones++;
                end
            end
            check("cmd_ready", {31'd0, cmd_ready}, {31'd0, rd_ptr == wr_ptr});
            if (aw_pend) check("aw_stable", {27'd0, AWVALID, AWADDR}, {27'd1, aw_prev});
            if (w_pend) begin
                check("wvalid_stable", {31'd0, WVALID}, 32'd1);
                check("wdata_stable", WDATA, w_prev);
            end
            if (ar_pend) check("ar_stable", {27'd0, ARVALID, ARADDR}, {27'd1, ar_prev});
        end
    end

    task automatic issue(input bit wr, input logic [3:0] a, input logic [31:0] d);
        int t = 0;
        while (!cmd_ready && t < 100) begin @(posedge ACLK); #1; t++; end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout: got cmd_ready=0 expected 1");
        end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        @(posedge ACLK); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (rd_ptr != wr_ptr && t < 200) begin @(posedge ACLK); #1; t++; end
        if (rd_ptr != wr_ptr) begin
            checks++; errors++;
            $display("FAIL done_timeout: got %0d outstanding expected 0", wr_ptr - rd_ptr);
            rd_ptr = wr_ptr;
        end
    endtask

    task automatic set_dly(input int a, input int w, input int ar, input int b, input int r, input logic [1:0] resp);
        aw_dly = a; w_dly = w; ar_dly = ar; b_dly = b; r_dly = r; cur_resp = resp;
    endtask

    initial begin
        int d0, t;
        ARESET = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_valids", {27'd0, AWVALID, WVALID, BREADY, ARVALID, RREADY}, 32'd0);
        check("rst_addr", {24'd0, AWADDR, ARADDR}, 32'd0);
        check("rst_wdata", WDATA, 32'd0);
        check("rst_rsp", rsp_data, 32'd0);
        check("rst_resp_done", {29'd0, rsp_resp, done}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("wstrb", {28'd0, WSTRB}, 32'hF);
        ARESET = 1'b0;

        set_dly(0, 0, 0, 0, 0, 2'b00);
        issue(1'b1, 4'h4, 32'hDEADBEEF);
        check("awaddr", {28'd0, AWADDR}, 32'h4);
        check("wdata", WDATA, 32'hDEADBEEF);
        wait_idle();
        issue(1'b0, 4'h4, 32'h0);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            if (i != 1) begin issue(1'b1, 4'(i * 4), $urandom); wait_idle(); end
        end

        set_dly(0, 5, 0, 0, 0, 2'b00);
        d0 = dones;
        issue(1'b1, 4'h8, 32'h1234_5678);
        wait_idle();
        check("aw_hi_cycles", aw_hi, 1);
        check("w_hi_cycles", w_hi, 6);
        check("bready_early", early, 0);
        check("single_done", dones - d0, 1);

        set_dly(0, 0, 0, 0, 0, 2'b10);
        issue(1'b0, 4'h8, 32'h0);
        wait_idle();
        check("idle_after_slverr", {31'd0, cmd_ready}, 32'd1);

        for (int n = 0; n < 60; n++) begin
            set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 4) == 0) set_dly(0, 0, 0, 0, 0, 2'b00);
            issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3) * 4), $urandom);
            wait_idle();
            if ($urandom_range(0, 3) == 0) begin
                stray_b = 1'($urandom_range(0, 1)); stray_r = !stray_b;
                repeat (2) @(posedge ACLK);
                #1 stray_b = 1'b0; stray_r = 1'b0;
            end
        end

        set_dly(0, 0, 0, 6, 0, 2'b00);
        issue(1'b1, 4'hC, 32'hCAFE_F00D);
        t = 0;
        while (!BREADY && t < 20) begin @(posedge ACLK); #1; t++; end
        check("reach_wr_resp", {31'd0, BREADY}, 32'd1);
        #2 ARESET = 1'b1;
        #1;
        check("mid_rst_valids", {27'd0, AWVALID, WVALID, BREADY, ARVALID, RREADY}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        @(posedge ACLK); #1 ARESET = 1'b0;
        check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("post_rst_rsp", {rsp_data[29:0], rsp_resp}, 32'd0);
        set_dly(0, 0, 0, 0, 0, 2'b00);
        issue(1'b1, 4'h0, 32'h0BAD_CAFE);
        wait_idle();
        issue(1'b0, 4'hC, 32'h0);
        wait_idle();

        d0 = accepts;
        hold_mode = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h4; cmd_wdata = 32'hA5A5_5A5A;
        t = 0;
        while (accepts - d0 < 4 && t < 100) begin @(posedge ACLK); #1; t++; end
        cmd_valid = 1'b0;
        hold_mode = 1'b0;
        check("hold_accepts", accepts - d0, 4);
        wait_idle();
        issue(1'b0, 4'h4, 32'h0);
        wait_idle();

        repeat (3) @(posedge ACLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1);
    end

endmodule
